// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte ports and the uart_core data_in handshake.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic busy;
  modport master (output req_data, req_valid, tx_ready, input req_ready, tx_data, tx_valid, grant_id, busy);
  modport slave (input req_data, req_valid, tx_ready, output req_ready, tx_data, tx_valid, grant_id, busy);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter with a one-entry buffer feeding uart_core data_in.
// Define UART_ARB_BURST_EN to let one grant carry up to BURST_LEN bytes; otherwise one byte per grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BURST_LEN = 8
) (
  input logic CLK_125MHZ_FPGA,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end
`ifdef UART_ARB_BURST_EN
  localparam logic [7:0] burst_max = 8'(BURST_LEN);
`else
  localparam logic [7:0] burst_max = 8'd1;
`endif
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] owner, rr_ptr, pick, idx;
  logic [7:0] cnt, buf_data;
  logic [7:0] req_byte [NUM_REQ];
  logic buf_valid, take, accept, done;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = bus.req_data[8*i +: 8];
  end
  // lowest offset from rr_ptr+1 wins, so the search runs from the far end down
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + 1 + k) % NUM_REQ);
      if (bus.req_valid[idx]) pick = idx;
    end
  end
  assign take = state == GRANT && (!buf_valid || bus.tx_ready);
  assign accept = take && bus.req_valid[owner];
  assign done = !bus.req_valid[owner] || (accept && cnt + 8'd1 == burst_max);
  assign bus.req_ready = take ? NUM_REQ'(1) << owner : '0;
  assign bus.tx_valid = buf_valid;
  assign bus.tx_data = buf_data;
  assign bus.grant_id = owner;
  assign bus.busy = state == GRANT || buf_valid;
  always_ff @(posedge CLK_125MHZ_FPGA) begin
    state <= rst ? IDLE : state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (|bus.req_valid ? GRANT : IDLE) : (done ? IDLE : GRANT);
  end
  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (rst) begin
      owner <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      cnt <= '0;
      buf_valid <= 1'b0;
      buf_data <= '0;
    end else begin
      if (accept) begin
        buf_valid <= 1'b1;
        buf_data <= req_byte[owner];
      end else if (bus.tx_ready) begin
        buf_valid <= 1'b0;
      end
      if (state == IDLE && |bus.req_valid) begin
        owner <= pick;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 8'd1;
      end
      if (state == GRANT && done) rr_ptr <= owner;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle reference model compared every cycle, plus directed byte-order scenarios.
module tb_uart_tx_arbiter;
  localparam int N = 4;
`ifdef UART_ARB_BURST_EN
  localparam int BL = 3;
  localparam int LIMIT = 3;
`else
  localparam int BL = 8;
  localparam int LIMIT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .BURST_LEN(BL)) dut (.CLK_125MHZ_FPGA(clk), .rst(rst), .bus(bus));
  always #4 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: grant ownership, round-robin pointer and a one-byte buffer
  bit m_grant, m_full, armed;
  int m_owner, m_rr, m_cnt;
  logic [7:0] m_byte;
  logic [7:0] dut_log [$];
  always @(posedge clk) begin
    bit acc, found;
    if (rst) begin
      m_grant = 0; m_full = 0; m_byte = 8'h00; m_rr = N - 1; m_cnt = 0; m_owner = 0; armed = 1;
    end else begin
      acc = m_grant && bus.req_valid[m_owner] && (!m_full || bus.tx_ready);
      if (acc) begin
        m_full = 1;
        m_byte = bus.req_data[8*m_owner +: 8];
      end else if (bus.tx_ready) m_full = 0;
      if (m_grant) begin
        m_cnt += int'(acc);
        if (!bus.req_valid[m_owner] || m_cnt == LIMIT) begin
          m_grant = 0;
          m_rr = m_owner;
        end
      end else if (bus.req_valid != 0) begin
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && bus.req_valid[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            found = 1;
          end
        m_grant = 1;
        m_cnt = 0;
      end
    end
  end
  always @(negedge clk) if (armed) begin
    chk("tx_valid", bus.tx_valid, m_full);
    chk("tx_data", bus.tx_data, m_byte);
    chk("req_ready", bus.req_ready, (m_grant && (!m_full || bus.tx_ready)) ? 32'(1) << m_owner : 0);
    chk("busy", bus.busy, m_grant || m_full);
    if (m_grant || m_full) chk("grant_id", bus.grant_id, m_owner);
    if (bus.tx_valid && bus.tx_ready && !rst) dut_log.push_back(bus.tx_data);
  end
  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
  endtask
  // requester i sends n[4i+:4] bytes, byte j of requester i is 8'h(i+1)j
  task automatic stream(input string name, input logic [15:0] n, input int nexp, input logic [79:0] exp);
    int sent [N];
    logic [N-1:0] hs;
    int cyc;
    dut_log.delete();
    for (int i = 0; i < N; i++) sent[i] = 0;
    bus.tx_ready = 1'b1;
    cyc = 0;
    forever begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = sent[i] < int'(n[4*i +: 4]);
        bus.req_data[8*i +: 8] = 8'((i + 1) * 16 + sent[i]);
      end
      if (bus.req_valid == 0 || cyc == 300) break;
      @(negedge clk) hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) sent[i]++;
      cyc++;
    end
    chk({name, "_finished"}, bus.req_valid, 0);
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_count"}, dut_log.size(), nexp);
    for (int k = 0; k < nexp && k < dut_log.size(); k++)
      chk($sformatf("%s_byte%0d", name, k), dut_log[k], exp[8*(nexp-1-k) +: 8]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed %0d", fails);
    $fatal(1);
  end
  initial begin
    do_reset();
    // first request reaches tx_valid two edges later
    bus.req_data[7:0] = 8'h41;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_idle_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_tx_valid_early", bus.tx_valid, 0);
    chk("t1_grant_id", bus.grant_id, 0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("t1_tx_valid", bus.tx_valid, 1);
    chk("t1_tx_data", bus.tx_data, 8'h41);
    chk("t1_owner", bus.grant_id, 0);
    repeat (3) @(posedge clk);
    #1;
    // rr_ptr is now 0: requester 1 goes first, then the next valid index after each owner
`ifdef UART_ARB_BURST_EN
    stream("t6_drop", 16'h1021, 4, {8'h20, 8'h21, 8'h40, 8'h10});
`else
    stream("t6_drop", 16'h1021, 4, {8'h20, 8'h40, 8'h10, 8'h21});
`endif
    do_reset();
`ifdef UART_ARB_BURST_EN
    stream("t2_all", 16'h2222, 8, {8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41});
`else
    stream("t2_all", 16'h2222, 8, {8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41});
`endif
    do_reset();
`ifdef UART_ARB_BURST_EN
    stream("t3_burst", 16'h0550, 10, {8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32, 8'h23, 8'h24, 8'h33, 8'h34});
`else
    stream("t3_burst", 16'h0550, 10, {8'h20, 8'h30, 8'h21, 8'h31, 8'h22, 8'h32, 8'h23, 8'h33, 8'h24, 8'h34});
`endif
    do_reset();
    // stalled sink holds the buffered byte
    bus.req_data[7:0] = 8'h55;
    bus.req_valid = 4'b0001;
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.req_data[7:0] = 8'h66;
    repeat (20) begin
      @(negedge clk);
      chk("t4_tx_valid", bus.tx_valid, 1);
      chk("t4_tx_data", bus.tx_data, 8'h55);
      chk("t4_ready0", bus.req_ready[0], 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    // reset pulse discards a full buffer and restores requester 0 priority
    bus.req_data[23:16] = 8'h77;
    bus.req_valid = 4'b0100;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_full", bus.tx_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 4'b0101;
    bus.req_data[7:0] = 8'h01;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_tx_valid", bus.tx_valid, 0);
    chk("t5_busy", bus.busy, 0);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_grant_id", bus.grant_id, 0);
    chk("t5_busy_grant", bus.busy, 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
